// File: rtl/axis_fifo_wr_arbiter_pkg.sv
// Shared encodings for the two-source AXI-Stream to FIFO write arbiter.
// State codes double as the one-hot grant value (OWN0 -> 01, OWN1 -> 10).
package axis_fifo_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [1:0] GNT_IDLE = 2'b00;
    localparam logic [1:0] GNT_S0   = 2'b01;
    localparam logic [1:0] GNT_S1   = 2'b10;

    // Width of the per-grant beat counter; it only needs to reach MAX_BEATS-1.
    function automatic int beat_cnt_w(input int max_beats);
        return (max_beats <= 2) ? 1 : $clog2(max_beats);
    endfunction

    function automatic logic [1:0] grant_of(input state_t st);
        case (st)
            ST_OWN0: return GNT_S0;
            ST_OWN1: return GNT_S1;
            default: return GNT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/axis_fifo_wr_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick: on a tie the source that did not own
// the port last wins. Returns the next arbiter state code.
module axis_fifo_wr_arbiter_rr_arb2
    import axis_fifo_wr_arbiter_pkg::*;
(
    input  logic   v0,
    input  logic   v1,
    input  logic   last_owner,
    output state_t next_state
);

    always_comb begin
        next_state = ST_IDLE;
        if (v0 && v1)
            next_state = last_owner ? ST_OWN0 : ST_OWN1;
        else if (v0)
            next_state = ST_OWN0;
        else if (v1)
            next_state = ST_OWN1;
    end

endmodule

// File: rtl/axis_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two AXI-Stream
// sources, with grant locked per packet. Optional packet counters: AXIS_FIFO_WR_ARBITER_PKT_COUNT_EN.
module axis_fifo_wr_arbiter
    import axis_fifo_wr_arbiter_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = 16,
    parameter int MAX_BEATS       = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AXIS_DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                       s0_axis_tlast,
    input  logic                       s0_axis_tvalid,
    output logic                       s0_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                       s1_axis_tlast,
    input  logic                       s1_axis_tvalid,
    output logic                       s1_axis_tready,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_wr_data,
    output logic                       fifo_wr_en,
    input  logic                       fifo_full,
`ifdef AXIS_FIFO_WR_ARBITER_PKT_COUNT_EN
    input  logic                       cnt_clear,
    output logic [31:0]                pkt_cnt0,
    output logic [31:0]                pkt_cnt1,
`endif
    output logic [1:0]                 grant
);

    localparam int CNT_W = beat_cnt_w(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    state_t           state;
    state_t           arb_next;
    logic             last_owner;   // 0 = S0, 1 = S1
    logic [CNT_W-1:0] beat_cnt;

    logic own0, own1, acc, cur_last, rel, arb_last;

    assign own0 = (state == ST_OWN0);
    assign own1 = (state == ST_OWN1);

    assign s0_axis_tready = own0 & ~fifo_full;
    assign s1_axis_tready = own1 & ~fifo_full;

    assign acc      = (s0_axis_tready & s0_axis_tvalid) | (s1_axis_tready & s1_axis_tvalid);
    assign cur_last = own1 ? s1_axis_tlast : s0_axis_tlast;
    assign rel      = acc & (cur_last | (beat_cnt == CNT_LAST));

    assign fifo_wr_en   = acc;
    assign fifo_wr_data = own0 ? s0_axis_tdata[FIFO_DATA_WIDTH-1:0] :
                          own1 ? s1_axis_tdata[FIFO_DATA_WIDTH-1:0] : '0;
    assign grant        = grant_of(state);

    // At release the finishing source counts as last owner, so a waiting peer wins.
    assign arb_last = own0 ? 1'b0 : own1 ? 1'b1 : last_owner;

    axis_fifo_wr_arbiter_rr_arb2 u_arb (
        .v0         (s0_axis_tvalid),
        .v1         (s1_axis_tvalid),
        .last_owner (arb_last),
        .next_state (arb_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= arb_next;
                ST_OWN0, ST_OWN1: begin
                    if (rel) begin
                        last_owner <= own1;
                        beat_cnt   <= '0;
                        state      <= arb_next;
                    end else if (acc) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    generate
        if (AXIS_DATA_WIDTH > FIFO_DATA_WIDTH) begin : g_hi_unused
            logic unused_hi;
            assign unused_hi = ^{s0_axis_tdata[AXIS_DATA_WIDTH-1:FIFO_DATA_WIDTH],
                                 s1_axis_tdata[AXIS_DATA_WIDTH-1:FIFO_DATA_WIDTH]};
        end
    endgenerate

`ifdef AXIS_FIFO_WR_ARBITER_PKT_COUNT_EN
    // Only real packet ends count; forced MAX_BEATS rotations do not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (cnt_clear) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (s0_axis_tready && s0_axis_tvalid && s0_axis_tlast)
                pkt_cnt0 <= pkt_cnt0 + 32'd1;
            if (s1_axis_tready && s1_axis_tvalid && s1_axis_tlast)
                pkt_cnt1 <= pkt_cnt1 + 32'd1;
        end
    end
`else
    // Packet counting compiled out; no extra state.
`endif

endmodule

// File: doc/axis_fifo_wr_arbiter.md
Name: axis_fifo_wr_arbiter

Overview:
- Shares one FIFO write port between two AXI-Stream sources: S0 is the DMA MM2S audio stream, S1 is the on-chip tone/test stream.
- Round-robin grant, locked for a whole packet (until the TLAST beat), so a packet is never interleaved with the other source.
- Sits between the two stream sources and the audio playback FIFO's write side.

Parameters:
- AXIS_DATA_WIDTH, 32, TDATA width of both slave ports.
- FIFO_DATA_WIDTH, 16, FIFO write width; the low FIFO_DATA_WIDTH bits of TDATA are written, must be <= AXIS_DATA_WIDTH.
- MAX_BEATS, 1024, maximum beats accepted per grant before forced rotation (guards against a missing TLAST); range 2..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- s0_axis_tdata  in  AXIS_DATA_WIDTH  source 0 data.
- s0_axis_tlast  in  1  source 0 end of packet.
- s0_axis_tvalid  in  1  source 0 valid.
- s0_axis_tready  out  1  source 0 ready.
- s1_axis_tdata  in  AXIS_DATA_WIDTH  source 1 data.
- s1_axis_tlast  in  1  source 1 end of packet.
- s1_axis_tvalid  in  1  source 1 valid.
- s1_axis_tready  out  1  source 1 ready.
- fifo_wr_data  out  FIFO_DATA_WIDTH  FIFO write data.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag.
- grant  out  2  one-hot current owner: 01 = S0, 10 = S1, 00 = idle.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values:
  - State IDLE; grant = 00.
  - Both tready = 0; fifo_wr_en = 0.
  - last_owner = S1, so S0 wins the first tie.
  - Beat counter = 0.
- States: IDLE, OWN0, OWN1. grant is the registered state decode.
- Datapath (combinational from state):
  - sN_axis_tready = (state == OWNn) & ~fifo_full.
  - Beat accepted: acc = tready & tvalid of the owner.
  - fifo_wr_en = acc.
  - fifo_wr_data = owner TDATA[FIFO_DATA_WIDTH-1:0]; 0 in IDLE.
- Arbitration function arb(v0, v1):
  - Only one valid: pick that source.
  - Both valid: pick the source that is not last_owner.
  - Neither valid: IDLE.
- IDLE: next state = arb(s0_tvalid, s1_tvalid). Grant is registered, so tready can rise one cycle after tvalid at the earliest.
- OWNn, release on an accepted beat when either:
  - tlast = 1, or
  - the beat counter equals MAX_BEATS-1.
- On release:
  - last_owner <= n; counter <= 0.
  - Next state = arb() evaluated on the current-cycle tvalids with last_owner = n. This gives back-to-back handover with no idle bubble.
  - Excluding the finishing source's current valid is not required; its next beat is treated as a new request.
- OWNn, no release: counter increments on each accepted beat. Owner tvalid low holds the grant; there is no timeout on idle cycles.
- fifo_full = 1: the owner's tready is 0; state and counter hold; the non-owner stays stalled.
- The non-owner's tready is always 0; its tvalid/tdata are ignored.
- Reset asserted mid-packet: immediate return to IDLE. A partial packet in the FIFO is not flushed (upstream's responsibility).
- TKEEP is not consumed; sources deliver full beats.
- Throughput: 1 beat/cycle while not full.

Optional Feature:
- Macro: AXIS_FIFO_WR_ARBITER_PKT_COUNT_EN.
- Defined:
  - Adds outputs pkt_cnt0 and pkt_cnt1 (each 32 bits, out).
  - Each increments on an accepted tlast beat of its source; a forced MAX_BEATS rotation does not count.
  - Counters wrap at 2^32 and reset to 0.
  - Adds input cnt_clear (1 bit, synchronous, zeroes both counters). If clear and increment occur in the same cycle, clear wins.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared header axis_fifo_arb_defs.vh holds:
  - State encodings ST_IDLE = 2'd0, ST_OWN0 = 2'd1, ST_OWN1 = 2'd2.
  - Grant encodings.
  - Beat-counter width = clog2(MAX_BEATS).
- One natural sub-module: rr_arb2, a combinational 2-way round-robin pick from (v0, v1, last_owner) returning a next-state code. Reused in IDLE and at release.

Test Plan:
- Reset, then S0 sends a 4-beat packet 0x0001..0x0004 (tlast on beat 4), S1 idle -> grant = 01 one cycle after tvalid; FIFO receives 0x0001..0x0004 in order; grant returns to 00 the cycle after.
- Both valid from IDLE, each with 3-beat packets (S0 0xA000+i, S1 0xB000+i) -> S0 first, then S1 with no bubble; FIFO order A0,A1,A2,B0,B1,B2; second round starts with S0 again.
- fifo_full held high for 5 cycles mid-packet after beat 2 of 4 -> both tready = 0, fifo_wr_en = 0, grant unchanged; beats 3 and 4 written after full drops, none lost or duplicated.
- MAX_BEATS = 8, S0 streams 20 beats with no tlast while S1 is valid -> S0 gets 8 beats, S1 packet served, S0 resumes at beat 9.
- TDATA = 0xDEAD_BEEF with FIFO_DATA_WIDTH = 16 -> fifo_wr_data = 0xBEEF; reset asserted mid-packet -> grant = 00, all tready = 0 asynchronously.
- With AXIS_FIFO_WR_ARBITER_PKT_COUNT_EN defined: S0 sends 3 packets, S1 sends 2 -> pkt_cnt0 = 3, pkt_cnt1 = 2; cnt_clear pulse coincident with an S1 tlast beat -> both counters read 0.
